// File: rtl/axi4l_write_master_p.sv
// -----------------------------------------------------------------------------
// axi4l_write_master_p
//
// Parametrised AXI4-Lite write master for the LSU/store path. It accepts one
// request per valid/ready handshake, latches address/data/strobes and drives
// the AW and W channels concurrently. Each channel's completion is tracked on
// its own. When both are complete the B response is accepted, captured into
// resp/err and reported with a one-cycle done pulse.
//
// Handshake rule (request side and all AXI channels): a transfer happens on a
// rising clk edge where valid and ready are both high. A valid is never
// withdrawn before its transfer. The payload stays stable while valid is high.
//
// Optional build macro:
//   AXI_WR_TIMEOUT_EN - adds a watchdog and the sticky 'timeout' output. Once a
//                       transaction has been outstanding for TIMEOUT_CYCLES
//                       cycles it is abandoned and completes with resp=2'b11.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake; req_ready is high only in IDLE
//   req_addr/data/strb  request payload, latched on acceptance
//   done                one-cycle pulse when a transaction finishes
//   resp, err           B response of the last finished transaction, and its bit 1
//   timeout             sticky watchdog flag (only with AXI_WR_TIMEOUT_EN)
//   AW_*, W_*, B_*      AXI4-Lite write address, write data and response channels
// -----------------------------------------------------------------------------
module axi4l_write_master_p #(
   parameter int         ADDR_W         = 64,
   parameter int         DATA_W         = 64,
   parameter logic [2:0] PROT           = 3'b000,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_data,
   input  logic [DATA_W/8-1:0]   req_strb,
   output logic                  done,
   output logic [1:0]            resp,
   output logic                  err,
`ifdef AXI_WR_TIMEOUT_EN
   output logic                  timeout,
`endif
   output logic [ADDR_W-1:0]     AW_ADDR,
   output logic [2:0]            AW_PROT,
   output logic                  AW_VALID,
   input  logic                  AW_READY,
   output logic [DATA_W-1:0]     W_DATA,
   output logic [DATA_W/8-1:0]   W_STRB,
   output logic                  W_VALID,
   input  logic                  W_READY,
   input  logic [1:0]            B_RESP,
   input  logic                  B_VALID,
   output logic                  B_READY
);

   localparam int STRB_W = DATA_W / 8;

   // Elaboration-time parameter checks.
   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("axi4l_write_master_p: DATA_W must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("axi4l_write_master_p: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT_B = 2'd2
   } state_t;

   state_t              state, state_n;
   logic                aw_done, aw_done_n;
   logic                w_done, w_done_n;
   logic                aw_valid_n, w_valid_n, b_ready_n;
   logic                done_n, err_n;
   logic [1:0]          resp_n;
   logic [ADDR_W-1:0]   aw_addr_n;
   logic [DATA_W-1:0]   w_data_n;
   logic [STRB_W-1:0]   w_strb_n;

   logic aw_hs, w_hs, b_hs;

   assign aw_hs     = AW_VALID & AW_READY;
   assign w_hs      = W_VALID & W_READY;
   assign b_hs      = B_VALID & B_READY;
   assign req_ready = (state == IDLE);
   assign AW_PROT   = PROT;

`ifdef AXI_WR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   // The counter reads 0 in the first busy cycle. done is registered, so
   // firing at count T-2 puts the done pulse exactly T cycles after acceptance.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [CNT_W-1:0] cnt, cnt_n;
   logic             timeout_n;
   logic             expire;

   assign expire = (cnt == CNT_LAST);
`endif

   always_comb begin
      state_n    = state;
      aw_valid_n = AW_VALID;
      w_valid_n  = W_VALID;
      b_ready_n  = B_READY;
      aw_done_n  = aw_done;
      w_done_n   = w_done;
      aw_addr_n  = AW_ADDR;
      w_data_n   = W_DATA;
      w_strb_n   = W_STRB;
      done_n     = 1'b0;
      resp_n     = resp;
      err_n      = err;
`ifdef AXI_WR_TIMEOUT_EN
      cnt_n      = cnt;
      timeout_n  = timeout;
`endif

      case (state)
         IDLE: begin
            if (req_valid) begin
               aw_addr_n  = req_addr;
               w_data_n   = req_data;
               w_strb_n   = req_strb;
               aw_valid_n = 1'b1;
               w_valid_n  = 1'b1;
               aw_done_n  = 1'b0;
               w_done_n   = 1'b0;
               state_n    = SEND;
`ifdef AXI_WR_TIMEOUT_EN
               cnt_n      = '0;
`endif
            end
         end
         SEND: begin
            if (aw_hs) begin
               aw_valid_n = 1'b0;
               aw_done_n  = 1'b1;
            end
            if (w_hs) begin
               w_valid_n = 1'b0;
               w_done_n  = 1'b1;
            end
            // A channel counts as complete if it finished earlier or is
            // handshaking right now; the two may finish in any order.
            if ((aw_done | aw_hs) & (w_done | w_hs)) begin
               b_ready_n = 1'b1;
               state_n   = WAIT_B;
            end
         end
         WAIT_B: begin
            if (b_hs) begin
               resp_n    = B_RESP;
               err_n     = B_RESP[1];
               done_n    = 1'b1;
               b_ready_n = 1'b0;
               state_n   = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

`ifdef AXI_WR_TIMEOUT_EN
      if (state != IDLE) begin
         cnt_n = cnt + 1'b1;
         // A B handshake in the expiry cycle wins over the watchdog.
         if (expire && !b_hs) begin
            aw_valid_n = 1'b0;
            w_valid_n  = 1'b0;
            b_ready_n  = 1'b0;
            done_n     = 1'b1;
            resp_n     = 2'b11;
            err_n      = 1'b1;
            timeout_n  = 1'b1;
            state_n    = IDLE;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         AW_VALID <= 1'b0;
         W_VALID  <= 1'b0;
         B_READY  <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         AW_ADDR  <= '0;
         W_DATA   <= '0;
         W_STRB   <= '0;
         done     <= 1'b0;
         resp     <= 2'b00;
         err      <= 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
         cnt      <= '0;
         timeout  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         AW_VALID <= aw_valid_n;
         W_VALID  <= w_valid_n;
         B_READY  <= b_ready_n;
         aw_done  <= aw_done_n;
         w_done   <= w_done_n;
         AW_ADDR  <= aw_addr_n;
         W_DATA   <= w_data_n;
         W_STRB   <= w_strb_n;
         done     <= done_n;
         resp     <= resp_n;
         err      <= err_n;
`ifdef AXI_WR_TIMEOUT_EN
         cnt      <= cnt_n;
         timeout  <= timeout_n;
`endif
      end
   end

endmodule

// File: tb/tb_axi4l_write_master_p.sv
// -----------------------------------------------------------------------------
// tb_axi4l_write_master_p
//
// Bench for axi4l_write_master_p with the default 64-bit address and data
// widths. It plays the request source and the AXI4-Lite slave.
//
// The reference model works on timestamps. It records the cycle of each
// acceptance and of each AW, W and B handshake. Every output follows from
// these stamps: AW valid is high from acceptance until its handshake, B ready
// is high once both AW and W are done, and done is high in the cycle after B.
// Directed sequences cover the main function, reset and the boundary cases.
// A randomised phase then exercises the same rules with random traffic.
// Inputs change at negedge+1; checks run at the negedge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi4l_write_master_p;

   localparam int TO = 16;
   localparam int QW = 64 + 64 + 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid, req_ready;
   logic [63:0] req_addr, req_data;
   logic [7:0]  req_strb;
   logic        done, err;
   logic [1:0]  resp;
   logic [63:0] AW_ADDR, W_DATA;
   logic [2:0]  AW_PROT;
   logic        AW_VALID, AW_READY, W_VALID, W_READY;
   logic [7:0]  W_STRB;
   logic [1:0]  B_RESP;
   logic        B_VALID, B_READY;
`ifdef AXI_WR_TIMEOUT_EN
   logic        timeout;
`endif

   axi4l_write_master_p #(
      .ADDR_W(64), .DATA_W(64), .PROT(3'b000), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
      .done(done), .resp(resp), .err(err),
`ifdef AXI_WR_TIMEOUT_EN
      .timeout(timeout),
`endif
      .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
      .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
      .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          cyc = 0;
   int          acc_cyc, aw_cyc, w_cyc, b_cyc, done_cyc;
   logic [63:0] m_addr, m_data;
   logic [7:0]  m_strb;
   logic [1:0]  m_resp;
   logic        m_err, m_timeout;
   logic [QW-1:0] exp_q[$];

   function automatic bit m_busy();
      return (acc_cyc >= 0) && (b_cyc < 0);
   endfunction
   function automatic bit m_aw_valid();
      return m_busy() && (aw_cyc < 0);
   endfunction
   function automatic bit m_w_valid();
      return m_busy() && (w_cyc < 0);
   endfunction
   function automatic bit m_b_ready();
      return m_busy() && (aw_cyc >= 0) && (w_cyc >= 0);
   endfunction

   task automatic reset_model();
      acc_cyc = -1; aw_cyc = -1; w_cyc = -1; b_cyc = -1; done_cyc = -1;
      m_addr = '0; m_data = '0; m_strb = '0;
      m_resp = 2'b00; m_err = 1'b0; m_timeout = 1'b0;
      exp_q.delete();
   endtask

   task automatic finish_txn(input logic [1:0] r);
      b_cyc    = cyc;
      done_cyc = cyc + 1;
      m_resp   = r;
      m_err    = r[1];
   endtask

   bit p_busy, p_aw, p_w, p_b;
   always @(posedge clk) begin
      if (rst) begin
         reset_model();
      end else begin
         p_busy = m_busy();
         p_aw   = m_aw_valid();
         p_w    = m_w_valid();
         p_b    = m_b_ready();
         if (!p_busy) begin
            if (req_valid) begin
               acc_cyc = cyc; aw_cyc = -1; w_cyc = -1; b_cyc = -1;
               m_addr = req_addr; m_data = req_data; m_strb = req_strb;
               exp_q.push_back({req_addr, req_data, req_strb});
            end
         end else begin
            if (p_aw && AW_READY) aw_cyc = cyc;
            if (p_w && W_READY) w_cyc = cyc;
            if (p_b && B_VALID) finish_txn(B_RESP);
`ifdef AXI_WR_TIMEOUT_EN
            else if (cyc - acc_cyc == TO - 1) begin
               finish_txn(2'b11);
               m_timeout = 1'b1;
            end
`endif
         end
      end
      cyc++;
   end

   // ---------------- compare process ----------------
   logic [QW-1:0] q_ent;
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("req_ready", req_ready, !m_busy());
         chk("aw_valid", AW_VALID, m_aw_valid());
         chk("w_valid", W_VALID, m_w_valid());
         chk("b_ready", B_READY, m_b_ready());
         chk("done", done, cyc == done_cyc);
         chk("resp", resp, m_resp);
         chk("err", err, m_err);
         chk("aw_addr", AW_ADDR, m_addr);
         chk("w_data", W_DATA, m_data);
         chk("w_strb", W_STRB, m_strb);
         chk("aw_prot", AW_PROT, 3'b000);
`ifdef AXI_WR_TIMEOUT_EN
         chk("timeout", timeout, m_timeout);
`endif
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("done_without_txn", done, 1'b0);
            end else begin
               q_ent = exp_q.pop_front();
               chk("sb_addr", AW_ADDR, q_ent[QW-1 -: 64]);
               chk("sb_data", W_DATA, q_ent[71:8]);
               chk("sb_strb", W_STRB, q_ent[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic set_slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br);
      AW_READY = awr; W_READY = wr; B_VALID = bv; B_RESP = br;
   endtask

   // Presents a request until accepted; returns the acceptance cycle and
   // leaves the bench in the following cycle with the request dropped.
   task automatic send_req(input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s, output int n);
      int budget;
      budget = 0;
      next_cycle();
      while (!req_ready && budget < 100) begin
         next_cycle();
         budget++;
      end
      chk("send_ready_budget", budget < 100, 1'b1);
      req_valid = 1'b1; req_addr = a; req_data = d; req_strb = s;
      n = cyc;
      next_cycle();
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      req_data  = {$urandom, $urandom};
      req_strb  = 8'($urandom);
   endtask

   task automatic wait_done(output int c);
      int k;
      c = -1;
      for (k = 0; k < 100; k++) begin
         next_cycle();
         if (done) begin
            c = cyc;
            break;
         end
      end
      chk("done_budget", k < 100, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   int n, d;
   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
      set_slave(1'b0, 1'b0, 1'b0, 2'b00);
      next_cycle();
      next_cycle();
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_aw_valid", AW_VALID, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_resp", resp, 2'b00);
      chk("rst_aw_addr", AW_ADDR, 64'h0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Best case: slave always ready with an OKAY response waiting.
      set_slave(1'b1, 1'b1, 1'b1, 2'b00);
      send_req(64'h0000_0000_8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, n);
      chk("t1_aw_valid_n1", AW_VALID, 1'b1);
      chk("t1_aw_addr_n1", AW_ADDR, 64'h0000_0000_8000_0010);
      wait_done(d);
      chk("t1_latency", d - n, 3);
      chk("t1_resp", resp, 2'b00);
      chk("t1_err", err, 1'b0);

      // AW_READY held off for 5 cycles, W_READY immediate.
      set_slave(1'b0, 1'b1, 1'b1, 2'b00);
      send_req(64'h1234_5678_0000_0100, 64'h0011_2233_4455_6677, 8'h3C, n);
      while (cyc < n + 6) begin
         next_cycle();
         if (cyc == n + 2) begin
            chk("t2_w_valid_low", W_VALID, 1'b0);
            chk("t2_aw_valid_held", AW_VALID, 1'b1);
         end
         if (cyc == n + 6) begin
            chk("t2_aw_addr_stable", AW_ADDR, 64'h1234_5678_0000_0100);
            AW_READY = 1'b1;
         end
      end
      wait_done(d);
      chk("t2_latency", d - n, 8);

      // B_VALID with SLVERR present before either channel completes.
      set_slave(1'b0, 1'b0, 1'b1, 2'b10);
      send_req(64'h0000_0000_0000_0FF8, 64'hCAFE_F00D_0000_0001, 8'h81, n);
      while (cyc < n + 5) begin
         next_cycle();
         if (cyc == n + 3) W_READY = 1'b1;
         if (cyc == n + 4) chk("t3_b_ready_low", B_READY, 1'b0);
         if (cyc == n + 5) AW_READY = 1'b1;
      end
      wait_done(d);
      chk("t3_latency", d - n, 7);
      chk("t3_resp", resp, 2'b10);
      chk("t3_err", err, 1'b1);

      // Back-to-back: second request accepted in the first done cycle.
      set_slave(1'b1, 1'b1, 1'b1, 2'b00);
      send_req(64'h0000_0000_0000_2000, 64'h1111_2222_3333_4444, 8'h0F, n);
      chk("t4_strb_first", W_STRB, 8'h0F);
      next_cycle();
      next_cycle();
      chk("t4_done_first", done, 1'b1);
      chk("t4_ready_in_done", req_ready, 1'b1);
      req_valid = 1'b1; req_addr = 64'h0000_0000_0000_2008;
      req_data = 64'h5555_6666_7777_8888; req_strb = 8'hF0;
      next_cycle();
      req_valid = 1'b0;
      chk("t4_strb_second", W_STRB, 8'hF0);
      chk("t4_resp_kept", resp, 2'b00);
      wait_done(d);
      chk("t4_latency", d - n, 6);

      // Reset asserted while both channels are still pending.
      set_slave(1'b0, 1'b0, 1'b0, 2'b00);
      send_req(64'h0000_0000_0000_3000, 64'h0BAD_0BAD_0BAD_0BAD, 8'hAA, n);
      chk("t5_aw_valid_before", AW_VALID, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t5_aw_valid_async", AW_VALID, 1'b0);
      chk("t5_w_valid_async", W_VALID, 1'b0);
      chk("t5_done_async", done, 1'b0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      next_cycle();
      chk("t5_ready_after", req_ready, 1'b1);
      chk("t5_no_done", done, 1'b0);
      chk("t5_w_strb_cleared", W_STRB, 8'h00);

`ifdef AXI_WR_TIMEOUT_EN
      // Slave never responds: the watchdog completes the transaction.
      set_slave(1'b1, 1'b1, 1'b0, 2'b00);
      send_req(64'h0000_0000_0000_4000, 64'h7777_7777_7777_7777, 8'hFF, n);
      wait_done(d);
      chk("t6_latency", d - n, TO);
      chk("t6_resp", resp, 2'b11);
      chk("t6_timeout", timeout, 1'b1);
`endif

      // Randomised traffic.
      for (int i = 0; i < 800; i++) begin
         next_cycle();
         req_valid = ($urandom_range(0, 2) != 0);
         req_addr  = {$urandom, $urandom};
         req_data  = {$urandom, $urandom};
         req_strb  = 8'($urandom);
         set_slave($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)));
      end

      // Drain anything outstanding.
      req_valid = 1'b0;
      set_slave(1'b1, 1'b1, 1'b1, 2'b00);
      for (int i = 0; i < 50; i++) begin
         next_cycle();
         if (!m_busy() && exp_q.size() == 0) break;
      end
      next_cycle();
      chk("drain_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/axi4l_write_master_p.md
Name: axi4l_write_master_p

Overview:
- Parametrised AXI4-Lite write master; successor to the fixed 64-bit single-shot write FSM.
- Accepts one write request per valid/ready handshake and latches address, data and byte strobes.
- Drives AW and W concurrently, with independent completion tracking per channel.
- Captures the 2-bit B response and reports it with a one-cycle done pulse.
- Sits between the core's LSU/store path and the AXI4-Lite interconnect.

Parameters:
- ADDR_W, 64, address width in bits.
- DATA_W, 64, data width in bits; must be 32 or 64; strobe width is DATA_W/8.
- PROT, 3'b000, constant value driven on AW_PROT.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when AXI_WR_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  master can accept a request.
- req_addr  in  ADDR_W  write address.
- req_data  in  DATA_W  write data.
- req_strb  in  DATA_W/8  byte-enable mask.
- done  out  1  one-cycle pulse: transaction finished.
- resp  out  2  B response of the last finished transaction.
- err  out  1  resp[1] of the last finished transaction (SLVERR or DECERR).
- AW_ADDR  out  ADDR_W  write address channel address.
- AW_PROT  out  3  write address channel protection, constant PROT.
- AW_VALID  out  1  write address valid.
- AW_READY  in  1  write address ready.
- W_DATA  out  DATA_W  write data.
- W_STRB  out  DATA_W/8  write strobes.
- W_VALID  out  1  write data valid.
- W_READY  in  1  write data ready.
- B_RESP  in  2  write response.
- B_VALID  in  1  write response valid.
- B_READY  out  1  write response ready.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1; AW_VALID=W_VALID=B_READY=0; done=0; resp=2'b00; err=0; address/data/strobe registers cleared to 0. Reset asserted mid-transaction drops all valids immediately, with no completion and no done pulse.
- All outputs are registered except req_ready, which is decoded combinationally from the state (1 only in IDLE).
- States: IDLE, SEND, WAIT_B.
- IDLE: on req_valid&req_ready, latch addr/data/strb into AW_ADDR/W_DATA/W_STRB, set AW_VALID=W_VALID=1, clear aw_done/w_done, go to SEND. Valids are visible the cycle after acceptance.
- SEND: an AW handshake (AW_VALID&AW_READY) clears AW_VALID next cycle and sets aw_done; a W handshake does the same for W_VALID/w_done. The two handshakes may occur in the same cycle or in either order. When both are complete (flag set, or handshake in the current cycle), go to WAIT_B with B_READY=1 next cycle.
- Valids never drop before their handshake. AW_ADDR, W_DATA and W_STRB stay stable from acceptance until done.
- WAIT_B: on B_VALID&B_READY, latch resp=B_RESP and err=B_RESP[1], pulse done=1 for one cycle, clear B_READY, go to IDLE.
- B_VALID arriving before both AW and W complete is ignored (B_READY=0).
- Best-case latency: accept at cycle N; AW/W handshakes at N+1; B_READY high at N+2; if B_VALID is already high, the B handshake occurs at N+2 and done is high at N+3.
- Back-to-back: req_ready returns to 1 in the same cycle done pulses, so the next accept can happen in that cycle.
- resp/err hold their values until the next done.
- Upper bits of req_addr are passed unchanged; no alignment check.

Optional Feature:
- Macro: AXI_WR_TIMEOUT_EN.
- Defined: a cycle counter (width $clog2(TIMEOUT_CYCLES)+1) clears on acceptance and increments in SEND and WAIT_B. On reaching TIMEOUT_CYCLES without a B handshake:
  - force AW_VALID=W_VALID=B_READY=0 and return to IDLE;
  - pulse done with resp=2'b11 and err=1;
  - assert sticky output timeout (1 bit, cleared only by rst).
- Not defined: no counter and no timeout port; transactions wait indefinitely.

Test Plan:
- Request addr=0x8000_0010, data=0xDEAD_BEEF_0123_4567, strb=8'hFF, with slave ready/valid always 1 -> AW and W handshakes at N+1, done at N+3, resp=2'b00, err=0.
- AW_READY delayed 5 cycles, W_READY immediate -> W_VALID drops at N+2, AW_VALID held with stable AW_ADDR until N+6, then B_READY rises.
- B_VALID held high from cycle 0 with B_RESP=2'b10 -> B is not accepted until both AW and W complete; then done with resp=2'b10, err=1.
- Two back-to-back requests (strb 8'h0F then 8'hF0) -> second accepted in the first done cycle; W_STRB shows each mask in order.
- rst asserted while in SEND -> AW_VALID/W_VALID fall asynchronously, no done pulse; req_ready=1 after reset release.
- With AXI_WR_TIMEOUT_EN and TIMEOUT_CYCLES=16, B_VALID held at 0 -> done at cycle 16 after acceptance, resp=2'b11, timeout=1.
